// File: rtl/bfloat_pkg.sv
// Shared definitions for the bfloat arithmetic family: flag indices,
// special-value constructors and operand classification.
package bfloat_pkg;

  // Bit positions inside the 2-bit flags output.
  localparam int FLAG_OVF = 0;
  localparam int FLAG_INV = 1;

  // Widest operand any member of the family supports (1 + 11 + 23).
  localparam int MAX_W = 35;

  localparam logic [MAX_W-1:0] ONE_W = {{(MAX_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  // The caller keeps the low 1+exp_w+man_w bits.
  function automatic logic [MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = ((ONE_W << exp_w) - ONE_W) << man_w;
    v = v | (ONE_W << (man_w - 1));
    return v;
  endfunction

  // Signed infinity: exponent all ones, mantissa zero.
  function automatic logic [MAX_W-1:0] infinity(input logic sign, input int exp_w, input int man_w);
    logic [MAX_W-1:0] v;
    v = ((ONE_W << exp_w) - ONE_W) << man_w;
    if (sign) begin
      v = v | (ONE_W << (exp_w + man_w));
    end else begin
      v = v;
    end
    return v;
  endfunction

  // Denormals (exp==0) count as zero; exp all-ones splits into inf/NaN.
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero);
    fp_class_t c;
    c.is_zero = exp_zero;
    c.is_inf  = exp_ones & man_zero;
    c.is_nan  = exp_ones & ~man_zero;
    return c;
  endfunction

endpackage

// File: rtl/bfloat_lzc.sv
// Combinational leading-zero counter. An all-zero input reports WIDTH.
module bfloat_lzc #(
  parameter int WIDTH = 11,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Scan LSB to MSB so the highest set bit determines the final count.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o = CNT_W'(WIDTH - 1 - i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/bfloat_addsub_pipe.sv
// Three-stage floating-point adder/subtractor with a single advance enable:
// align -> add/normalise -> round/pack. Specials bypass the arithmetic.
module bfloat_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic [1:0]   flags
);
  import bfloat_pkg::*;

  // Significand field: hidden bit, MAN_W bits, guard, round, sticky.
  localparam int F      = MAN_W + 4;
  localparam int CNT_W  = $clog2(F + 1);
  localparam int SH_MAX = MAN_W + 3;
  localparam int EW2    = EXP_W + 2;

  localparam logic [MAX_W-1:0] NAN_FULL  = canonical_nan(EXP_W, MAN_W);
  localparam logic [MAX_W-1:0] PINF_FULL = infinity(1'b0, EXP_W, MAN_W);
  localparam logic [MAX_W-1:0] NINF_FULL = infinity(1'b1, EXP_W, MAN_W);
  localparam logic [W-1:0]     NAN_C     = NAN_FULL[W-1:0];
  localparam logic [W-1:0]     PINF_C    = PINF_FULL[W-1:0];
  localparam logic [W-1:0]     NINF_C    = NINF_FULL[W-1:0];
  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};

  logic adv_s;

  // ---------------- stage 1: classify, swap, align ----------------
  logic             sign_a_s, sign_b_s, sign_l_s, sign_sm_s;
  logic [EXP_W-1:0] exp_a_s, exp_b_s, exp_l_s, exp_sm_s, diff_s;
  logic [MAN_W-1:0] man_a_s, man_b_s;
  fp_class_t        cls_a_s, cls_b_s;
  logic [W-2:0]     mag_a_s, mag_b_s, mag_l_s, mag_sm_s;
  logic [31:0]      sh_s;
  logic [2*F-1:0]   ext_s;
  logic [F-1:0]     sig_l_s, sig_al_s;
  logic             special_s, any_nan_s;
  logic [W-1:0]     spec_val_s;
  logic [1:0]       spec_flags_s;

  logic             s1_valid_q, s1_special_q, s1_sign_q, s1_eff_add_q;
  logic [W-1:0]     s1_spec_val_q;
  logic [1:0]       s1_spec_flags_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [F-1:0]     s1_sig_l_q, s1_sig_s_q;

  // ---------------- stage 2: add/subtract and normalise ----------------
  logic [F:0]              sum2_s;
  logic [CNT_W-1:0]        lz_s;
  logic signed [EW2-1:0]   exp2_s;
  logic [F-1:0]            norm_s;
  logic                    zero2_s, sign2_s;

  logic             s2_valid_q, s2_special_q, s2_zero_q, s2_sign_q;
  logic [W-1:0]     s2_spec_val_q;
  logic [1:0]       s2_spec_flags_q;
  logic [EXP_W:0]   s2_exp_q;
  logic [F-1:0]     s2_sig_q;

  // ---------------- stage 3: round and pack ----------------
  logic             inc_s;
  logic [MAN_W+1:0] rnd_s;
  logic [EXP_W+1:0] exp3_s;
  logic [MAN_W-1:0] man3_s;
  logic [W-1:0]     res_s;
  logic [1:0]       flags3_s;

  logic             out_valid_q;
  logic [W-1:0]     sum_q;
  logic [1:0]       flags_q;

  // The whole pipe moves together unless a finished result is stalled.
  assign adv_s     = !out_valid_q || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

  // Stage 1 datapath: resolve specials, order by magnitude, align smaller operand.
  always_comb begin
    sign_a_s = a[W-1];
    sign_b_s = b[W-1] ^ sub;
    exp_a_s  = a[W-2:MAN_W];
    exp_b_s  = b[W-2:MAN_W];
    man_a_s  = a[MAN_W-1:0];
    man_b_s  = b[MAN_W-1:0];
    cls_a_s  = fp_classify(exp_a_s == {EXP_W{1'b0}}, exp_a_s == EXP_ONES, man_a_s == {MAN_W{1'b0}});
    cls_b_s  = fp_classify(exp_b_s == {EXP_W{1'b0}}, exp_b_s == EXP_ONES, man_b_s == {MAN_W{1'b0}});
    // Denormals become zero magnitude before the compare.
    mag_a_s  = cls_a_s.is_zero ? {(W-1){1'b0}} : a[W-2:0];
    mag_b_s  = cls_b_s.is_zero ? {(W-1){1'b0}} : b[W-2:0];

    if (mag_a_s >= mag_b_s) begin
      mag_l_s   = mag_a_s;
      sign_l_s  = sign_a_s;
      mag_sm_s  = mag_b_s;
      sign_sm_s = sign_b_s;
    end else begin
      mag_l_s   = mag_b_s;
      sign_l_s  = sign_b_s;
      mag_sm_s  = mag_a_s;
      sign_sm_s = sign_a_s;
    end

    exp_l_s  = mag_l_s[W-2:MAN_W];
    exp_sm_s = mag_sm_s[W-2:MAN_W];
    sig_l_s  = {(exp_l_s != {EXP_W{1'b0}}), mag_l_s[MAN_W-1:0], 3'b000};
    diff_s   = exp_l_s - exp_sm_s;

    if (32'(diff_s) > 32'(SH_MAX)) begin
      sh_s = 32'(SH_MAX);
    end else begin
      sh_s = 32'(diff_s);
    end

    // Lower half of the double-width field collects everything shifted out.
    ext_s    = {(exp_sm_s != {EXP_W{1'b0}}), mag_sm_s[MAN_W-1:0], 3'b000, {F{1'b0}}} >> sh_s;
    sig_al_s = ext_s[2*F-1:F] | {{(F-1){1'b0}}, (|ext_s[F-1:0])};

    any_nan_s    = cls_a_s.is_nan | cls_b_s.is_nan |
                   (cls_a_s.is_inf & cls_b_s.is_inf & (sign_a_s != sign_b_s));
    special_s    = any_nan_s | cls_a_s.is_inf | cls_b_s.is_inf;
    spec_flags_s = 2'b00;
    if (any_nan_s) begin
      spec_val_s             = NAN_C;
      spec_flags_s[FLAG_INV] = 1'b1;
    end else if (cls_a_s.is_inf) begin
      spec_val_s = sign_a_s ? NINF_C : PINF_C;
    end else if (cls_b_s.is_inf) begin
      spec_val_s = sign_b_s ? NINF_C : PINF_C;
    end else begin
      spec_val_s = {W{1'b0}};
    end
  end

  // Stage 1 registers, loaded on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_special_q    <= 1'b0;
      s1_spec_val_q   <= {W{1'b0}};
      s1_spec_flags_q <= 2'b00;
      s1_sign_q       <= 1'b0;
      s1_eff_add_q    <= 1'b0;
      s1_exp_q        <= {EXP_W{1'b0}};
      s1_sig_l_q      <= {F{1'b0}};
      s1_sig_s_q      <= {F{1'b0}};
    end else if (adv_s) begin
      s1_valid_q      <= in_valid;
      s1_special_q    <= special_s;
      s1_spec_val_q   <= spec_val_s;
      s1_spec_flags_q <= spec_flags_s;
      s1_sign_q       <= sign_l_s;
      s1_eff_add_q    <= (sign_l_s == sign_sm_s);
      s1_exp_q        <= exp_l_s;
      s1_sig_l_q      <= sig_l_s;
      s1_sig_s_q      <= sig_al_s;
    end
  end

  bfloat_lzc #(.WIDTH(F)) u_lzc (
    .data_i  (sum2_s[F-1:0]),
    .count_o (lz_s)
  );

  // Stage 2 datapath: magnitude add/subtract, then normalise or flush.
  always_comb begin
    if (s1_eff_add_q) begin
      sum2_s = {1'b0, s1_sig_l_q} + {1'b0, s1_sig_s_q};
    end else begin
      sum2_s = {1'b0, s1_sig_l_q} - {1'b0, s1_sig_s_q};
    end

    norm_s  = {F{1'b0}};
    exp2_s  = {EW2{1'b0}};
    zero2_s = 1'b0;
    sign2_s = s1_sign_q;

    if (sum2_s == {(F+1){1'b0}}) begin
      // Cancellation gives +0; only two equal-signed zeros keep their sign.
      zero2_s = 1'b1;
      sign2_s = s1_eff_add_q ? s1_sign_q : 1'b0;
    end else if (sum2_s[F]) begin
      norm_s  = {sum2_s[F:2], sum2_s[1] | sum2_s[0]};
      exp2_s  = $signed({2'b00, s1_exp_q}) + $signed({{(EW2-1){1'b0}}, 1'b1});
      zero2_s = 1'b0;
      sign2_s = s1_sign_q;
    end else begin
      norm_s  = sum2_s[F-1:0] << lz_s;
      exp2_s  = $signed({2'b00, s1_exp_q}) - $signed(EW2'(lz_s));
      // Results below the minimum normal flush to +0.
      zero2_s = (exp2_s <= $signed({EW2{1'b0}}));
      sign2_s = zero2_s ? 1'b0 : s1_sign_q;
    end
  end

  // Stage 2 registers, loaded on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q      <= 1'b0;
      s2_special_q    <= 1'b0;
      s2_spec_val_q   <= {W{1'b0}};
      s2_spec_flags_q <= 2'b00;
      s2_zero_q       <= 1'b0;
      s2_sign_q       <= 1'b0;
      s2_exp_q        <= {(EXP_W+1){1'b0}};
      s2_sig_q        <= {F{1'b0}};
    end else if (adv_s) begin
      s2_valid_q      <= s1_valid_q;
      s2_special_q    <= s1_special_q;
      s2_spec_val_q   <= s1_spec_val_q;
      s2_spec_flags_q <= s1_spec_flags_q;
      s2_zero_q       <= zero2_s;
      s2_sign_q       <= sign2_s;
      s2_exp_q        <= exp2_s[EXP_W:0];
      s2_sig_q        <= norm_s;
    end
  end

  // Stage 3 datapath: round to nearest even, detect overflow, pack.
  always_comb begin
    inc_s = s2_sig_q[2] & (s2_sig_q[1] | s2_sig_q[0] | s2_sig_q[3]);
    rnd_s = {1'b0, s2_sig_q[F-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};

    if (rnd_s[MAN_W+1]) begin
      exp3_s = {1'b0, s2_exp_q} + {{(EXP_W+1){1'b0}}, 1'b1};
      man3_s = rnd_s[MAN_W:1];
    end else begin
      exp3_s = {1'b0, s2_exp_q};
      man3_s = rnd_s[MAN_W-1:0];
    end

    flags3_s = 2'b00;
    if (s2_special_q) begin
      res_s    = s2_spec_val_q;
      flags3_s = s2_spec_flags_q;
    end else if (s2_zero_q) begin
      res_s = {s2_sign_q, {(W-1){1'b0}}};
    end else if (exp3_s >= {2'b00, EXP_ONES}) begin
      res_s              = s2_sign_q ? NINF_C : PINF_C;
      flags3_s[FLAG_OVF] = 1'b1;
    end else begin
      res_s = {s2_sign_q, exp3_s[EXP_W-1:0], man3_s};
    end
  end

  // Output registers; data only changes when a real result advances in.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= {W{1'b0}};
      flags_q     <= 2'b00;
    end else if (adv_s) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        sum_q   <= res_s;
        flags_q <= flags3_s;
      end
    end
  end

endmodule

// File: tb/tb_bfloat_addsub_pipe.sv
// Scoreboard bench for bfloat_addsub_pipe (EXP_W=8, MAN_W=7).
module tb_bfloat_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic [1:0]  flags;

  int          n_chk = 0;
  int          n_pass = 0;
  int          out_count = 0;
  int          pat_idx = 0;
  logic        rdy_mode = 1'b0;
  logic        stall_prev = 1'b0;
  logic [17:0] held = 18'h0;
  logic [17:0] mon_e;
  logic [17:0] exp_q[$];

  localparam int NV = 19;
  logic [15:0] tv_a [NV] = '{16'h3F80, 16'h4040, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F81, 16'h3F80,
                             16'h7F7F, 16'h7F80, 16'h7FC1, 16'h0001, 16'h8000, 16'h8000, 16'h3F80,
                             16'h7F80, 16'h0090, 16'h3F80, 16'h3F80, 16'hBF80};
  logic [15:0] tv_b [NV] = '{16'h3F80, 16'h3F80, 16'hBF80, 16'h3F80, 16'h3B80, 16'h3B80, 16'h3BC0,
                             16'h7F7F, 16'hFF80, 16'h3F80, 16'h3F80, 16'h8000, 16'h0000, 16'h7F80,
                             16'h7F80, 16'h0080, 16'hC040, 16'h3380, 16'h3F80};
  logic        tv_s [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] tv_e [NV] = '{16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h3F80, 16'h3F82, 16'h3F81,
                             16'h7F80, 16'h7FC0, 16'h7FC0, 16'h3F80, 16'h8000, 16'h0000, 16'h7F80,
                             16'h7FC0, 16'h0000, 16'hC000, 16'h3F80, 16'hC000};
  logic [1:0]  tv_f [NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b10, 2'b00, 2'b00, 2'b00, 2'b00};

  // Backpressure stream: n+m pairs of small integers.
  logic [15:0] bp_a [8] = '{16'h3F80, 16'h3F80, 16'h4000, 16'h4000, 16'h4040, 16'h4040, 16'h4080, 16'h4080};
  logic [15:0] bp_b [8] = '{16'h3F80, 16'h4000, 16'h4000, 16'h4040, 16'h4040, 16'h4080, 16'h4080, 16'h40A0};
  logic [15:0] bp_e [8] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100, 16'h4110};

  bfloat_addsub_pipe #(.EXP_W(8), .MAN_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Consumer readiness changes just after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rdy_mode) begin
      out_ready = (pat_idx == 0) || (pat_idx == 3);
      pat_idx   = (pat_idx + 1) % 4;
    end else begin
      out_ready = 1'b1;
      pat_idx   = 0;
    end
  end

  // Monitor: handshake rules, stall hold, and in-order scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (stall_prev) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data", 32'({sum, flags}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got sum 0x%0h flags %b, expected no result", sum, flags);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_sum", 32'(sum), 32'(mon_e[17:2]));
          check("result_flags", 32'(flags), 32'(mon_e[1:0]));
        end
        out_count++;
      end
      stall_prev = out_valid && !out_ready;
      held       = {sum, flags};
    end
  end

  // Present one pair, wait for acceptance, and record the expected result.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic [15:0] es, input logic [1:0] ef);
    int g;
    @(negedge clk);
    a = av;
    b = bv;
    sub = sv;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("issue_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back({es, ef});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    int base;
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, issued back to back.
    for (int i = 0; i < NV; i++) begin
      issue(tv_a[i], tv_b[i], tv_s[i], tv_e[i], tv_f[i]);
    end
    drain("drain_directed");

    // Backpressure stream with out_ready pattern 1,0,0,1.
    rdy_mode = 1'b1;
    base = out_count;
    for (int i = 0; i < 8; i++) begin
      issue(bp_a[i], bp_b[i], 1'b0, bp_e[i], 2'b00);
    end
    drain("drain_backpressure");
    check("backpressure_count", 32'(out_count - base), 32'd8);
    rdy_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset with two operations in flight: neither may emerge.
    base = out_count;
    issue(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 2'b00);
    issue(16'h4040, 16'h3F80, 1'b0, 16'h4080, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_discard_valid", 32'(out_valid), 32'd0);
    end
    check("reset_discard_count", 32'(out_count - base), 32'd0);

    // Fresh pair after reset: three-edge latency.
    issue(16'h4000, 16'h3F80, 1'b0, 16'h4040, 2'b00);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("post_reset_latency", 32'(lat), 32'd3);
    drain("drain_post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
